// File: rtl/fibre_store_pkg.sv
// fibre_store_pkg: shared types and constants for the fibre_a store.
//   state_t      - load-sequence FSM states
//   fibre_t      - one spike fibre word at the default width
//   rd_flags_t   - per-read flags carried through the first pipeline stage
//   READ_LATENCY - request-to-result cycles; the accumulator_correction wait
//                  counter uses the same value
package fibre_store_pkg;

  localparam int DEF_TIMESTEPS = 16;
  localparam int READ_LATENCY  = 2;

  typedef logic [DEF_TIMESTEPS-1:0] fibre_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  typedef struct packed {
    logic fwd;   // same-cycle write to the read address: use forwarded data
    logic miss;  // entry unwritten at the request cycle
  } rd_flags_t;

endpackage

// File: rtl/fibre_store_ram.sv
// fibre_store_ram: 1-write / 1-read synchronous array, no reset.
//   clk            clock
//   wr_en/addr/data write port, committed at the clock edge
//   rd_en/addr     read request; rd_data is registered (1-cycle latency)
//   rd_data        array contents before any same-edge write (read-old)
module fibre_store_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fibre_a_store.sv
// fibre_a_store: responder for the TPPE fibre_a read interface.
// Holds one spike fibre per address, filled through a valid/ready load port,
// and answers reads with a fixed 2-cycle latency. Per-entry written bits flag
// reads of never-loaded entries (fibre_a_miss) instead of returning stale data.
//   clk, rst_n                  clock, async active-low reset
//   load_valid/ready/addr/data  write beat handshake; load_last ends a sequence
//   clear                       1-cycle pulse: invalidate all entries, go IDLE
//   fibre_a_read_en/addr        read request (at most one per cycle)
//   fibre_a_valid/data/miss     read result, request cycle + 2
//   store_ready                 load sequence complete
//   fibre_count                 number of distinct entries written
module fibre_a_store
  import fibre_store_pkg::*;
#(
  parameter int TIMESTEPS  = DEF_TIMESTEPS,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [TIMESTEPS-1:0]  load_data,
  input  logic                  load_last,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
  input  logic                  fibre_a_read_en,
  output logic [TIMESTEPS-1:0]  fibre_a_data,
  output logic                  fibre_a_valid,
  output logic                  fibre_a_miss,
  output logic                  store_ready,
  output logic [ADDR_WIDTH:0]   fibre_count
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int STAGES = READ_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t               state;
  logic [DEPTH-1:0]     written;
  logic                 beat;
  logic                 fwd_hit;
  rd_flags_t            rd_flags;
  rd_flags_t            s1_flags;
  logic [TIMESTEPS-1:0] s1_fwd_data;
  logic [TIMESTEPS-1:0] ram_q;
  logic [STAGES:0]      vld_pipe;

  assign load_ready = (state != ST_READY) && !clear;
  assign beat       = load_valid && load_ready;

  // Write-through: a beat landing on the read address this cycle is not yet
  // in the array or the written bits, so the read takes it from the port.
  assign fwd_hit       = beat && (load_addr == fibre_a_addr);
  assign rd_flags.fwd  = fwd_hit;
  assign rd_flags.miss = !(written[fibre_a_addr] || fwd_hit);

  fibre_store_ram #(
    .WIDTH (TIMESTEPS),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (beat),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (fibre_a_read_en),
    .rd_addr (fibre_a_addr),
    .rd_data (ram_q)
  );

  // Load-sequence FSM; store_ready is the registered READY indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      store_ready <= 1'b0;
    end else if (clear) begin
      state       <= ST_IDLE;
      store_ready <= 1'b0;
    end else if (beat) begin
      if (load_last) begin
        state       <= ST_READY;
        store_ready <= 1'b1;
      end else begin
        state <= ST_LOADING;
      end
    end
  end

  // Written bits and distinct-entry count. A beat can never coincide with
  // clear (load_ready is low), so clear simply wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written     <= '0;
      fibre_count <= '0;
    end else if (clear) begin
      written     <= '0;
      fibre_count <= '0;
    end else if (beat) begin
      written[load_addr] <= 1'b1;
      if (!written[load_addr] && (fibre_count != FULL_COUNT))
        fibre_count <= fibre_count + 1'b1;
    end
  end

  // Read pipeline. Stage 1 captures the request-cycle flags alongside the
  // array read, so later writes or a clear cannot alter an in-flight read.
  // Stage 2 selects forward/array data and zeroes data on miss or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s1_flags     <= '0;
      s1_fwd_data  <= '0;
      fibre_a_data <= '0;
      fibre_a_miss <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], fibre_a_read_en};
      if (fibre_a_read_en) begin
        s1_flags    <= rd_flags;
        s1_fwd_data <= load_data;
      end
      fibre_a_miss <= vld_pipe[0] && s1_flags.miss;
      if (vld_pipe[0] && !s1_flags.miss)
        fibre_a_data <= s1_flags.fwd ? s1_fwd_data : ram_q;
      else
        fibre_a_data <= '0;
    end
  end

  assign fibre_a_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_fibre_a_store.sv
// tb_fibre_a_store: directed plus randomized bench for fibre_a_store.
// The reference model is a plain array of stored fibres, a written flag per
// address, a count, a "sequence complete" flag and a queue of expected read
// results tagged with the cycle they are due.
module tb_fibre_a_store;
  import fibre_store_pkg::*;

  localparam int TS    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  fibre_t        load_data;
  logic          load_last;
  logic          clear;
  logic [AW-1:0] fibre_a_addr;
  logic          fibre_a_read_en;
  fibre_t        fibre_a_data;
  logic          fibre_a_valid;
  logic          fibre_a_miss;
  logic          store_ready;
  logic [AW:0]   fibre_count;

  fibre_a_store #(.TIMESTEPS(TS), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_last       (load_last),
    .clear           (clear),
    .fibre_a_addr    (fibre_a_addr),
    .fibre_a_read_en (fibre_a_read_en),
    .fibre_a_data    (fibre_a_data),
    .fibre_a_valid   (fibre_a_valid),
    .fibre_a_miss    (fibre_a_miss),
    .store_ready     (store_ready),
    .fibre_count     (fibre_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    logic   miss;
    fibre_t data;
  } exp_t;

  exp_t   q[$];
  fibre_t m_mem [DEPTH];
  bit     m_wr  [DEPTH];
  int     m_cnt;
  bit     m_ready;
  int     cyc;
  int     checks;
  int     errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    m_cnt   = 0;
    m_ready = 1'b0;
  endtask

  // Compare all registered outputs against the model for the current cycle.
  task automatic check_outputs();
    exp_t e;
    logic ev;
    e.miss = 1'b0;
    e.data = '0;
    ev     = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      ev = 1'b1;
    end
    chk("fibre_a_valid", 32'(fibre_a_valid), 32'(ev));
    chk("fibre_a_data",  32'(fibre_a_data),  32'(e.data));
    chk("fibre_a_miss",  32'(fibre_a_miss),  32'(e.miss));
    chk("store_ready",   32'(store_ready),   32'(m_ready));
    chk("fibre_count",   32'(fibre_count),   32'(m_cnt));
  endtask

  // One clock cycle: check outputs, drive inputs, check load_ready, advance
  // the model by the rules of the block, then move to the next negedge.
  task automatic step(input bit lv, input logic [AW-1:0] la, input fibre_t ld,
                      input bit ll, input bit clr, input bit re,
                      input logic [AW-1:0] ra);
    bit   acc;
    bit   hit;
    exp_t e;
    check_outputs();
    load_valid      = lv;
    load_addr       = la;
    load_data       = ld;
    load_last       = ll;
    clear           = clr;
    fibre_a_read_en = re;
    fibre_a_addr    = ra;
    #1;
    chk("load_ready", 32'(load_ready), 32'(!m_ready && !clr));
    acc = lv && !m_ready && !clr;
    hit = acc && (la == ra);
    if (re) begin
      e.due  = cyc + READ_LATENCY;
      e.miss = !(m_wr[ra] || hit);
      e.data = e.miss ? '0 : (hit ? ld : m_mem[ra]);
      q.push_back(e);
    end
    if (clr) begin
      foreach (m_wr[i]) m_wr[i] = 1'b0;
      m_cnt   = 0;
      m_ready = 1'b0;
    end else if (acc) begin
      if (!m_wr[la] && m_cnt < DEPTH) m_cnt++;
      m_wr[la]  = 1'b1;
      m_mem[la] = ld;
      if (ll) m_ready = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0, 0, 0, 0, '0);
  endtask

  task automatic ld(input logic [AW-1:0] a, input fibre_t d, input bit last);
    step(1, a, d, last, 0, 0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, '0, '0, 0, 0, 1, a);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_reset();
    rst_n = 1'b0;
    load_valid = 0; load_addr = '0; load_data = '0; load_last = 0;
    clear = 0; fibre_a_addr = '0; fibre_a_read_en = 0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_valid",       32'(fibre_a_valid), 32'(0));
    chk("rst_data",        32'(fibre_a_data),  32'(0));
    chk("rst_miss",        32'(fibre_a_miss),  32'(0));
    chk("rst_store_ready", 32'(store_ready),   32'(0));
    chk("rst_count",       32'(fibre_count),   32'(0));
    chk("rst_load_ready",  32'(load_ready),    32'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Load 0..3, last on 3
    ld(0, 16'h0001, 0);
    ld(1, 16'h00F0, 0);
    ld(2, 16'hFFFF, 0);
    ld(3, 16'h8000, 1);
    chk("count_after_load4", 32'(fibre_count), 32'(4));
    chk("ready_after_last",  32'(store_ready), 32'(1));

    // Back-to-back reads, then a never-written entry
    rd(3); rd(2); rd(1); rd(0);
    rd(9);
    idle(3);

    // READY: beat refused and not stored
    step(1, 7, 16'hBEEF, 0, 0, 0, '0);
    rd(7);
    idle(2);

    // Clear with a same-cycle read of 0 (pre-clear view), then a post-clear read
    step(0, '0, '0, 0, 1, 1, 0);
    rd(0);
    chk("count_after_clear", 32'(fibre_count), 32'(0));
    chk("ready_after_clear", 32'(store_ready), 32'(0));
    idle(2);

    // Write-through on same address, then rewrite without count change
    step(1, 5, 16'hA5A5, 0, 0, 1, 5);
    ld(5, 16'h1234, 0);
    rd(5);
    chk("count_rewrite", 32'(fibre_count), 32'(1));
    idle(2);

    // Clear and a beat in the same cycle: beat dropped
    step(1, 6, 16'h6666, 0, 1, 0, '0);
    rd(6);
    idle(2);

    // Fill every address, rewrite one with last: count pinned at full depth
    for (int a = 0; a < DEPTH; a++) ld(AW'(a), fibre_t'($urandom), 0);
    ld(10, 16'hC0DE, 1);
    chk("count_full", 32'(fibre_count), 32'(DEPTH));
    rd(10); rd(255); rd(0);
    idle(3);

    // Reset between a read and its result: no valid pulse survives
    rd(10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",      32'(fibre_a_valid), 32'(0));
    chk("mid_rst_data",       32'(fibre_a_data),  32'(0));
    chk("mid_rst_miss",       32'(fibre_a_miss),  32'(0));
    chk("mid_rst_count",      32'(fibre_count),   32'(0));
    chk("mid_rst_store_rdy",  32'(store_ready),   32'(0));
    chk("mid_rst_load_ready", 32'(load_ready),    32'(1));
    @(negedge clk);
    chk("mid_rst_valid_n2",   32'(fibre_a_valid), 32'(0));
    model_reset();
    rst_n = 1'b1;
    cyc++;
    chk("post_rst_load_ready", 32'(load_ready), 32'(1));
    rd(10);
    idle(3);

    // Randomized traffic over a small address window to force collisions
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] la, ra;
      la = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? la : AW'($urandom_range(0, 17));
      step($urandom_range(0, 1) == 1, la, fibre_t'($urandom),
           $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, ra);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
